// File: rtl/clock_time_counter.sv
// Timekeeping core: 1 Hz prescaler, hh:mm:ss counters and set-time FSM.
// Optional 12-hour presentation with pm flag when TIME_12H_EN is defined.
module clock_time_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [5:0] hour,
  output logic       sec_tick,
  output logic [1:0] set_state,
  output logic       blink
`ifdef TIME_12H_EN
  ,
  output logic       pm
`endif
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOUR = 2'b01,
    S_MIN  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [5:0]    r_hour;
  logic          r_sec_tick;

  logic w_tick;
  logic w_exit;
  logic w_inc;
  logic w_run_tick;

  assign w_tick     = (r_cnt == CW'(TICK_DIV - 1));
  assign w_exit     = (r_state == S_MIN) && btn_mode;
  // btn_mode takes priority over a coincident btn_inc
  assign w_inc      = btn_inc && !btn_mode;
  assign w_run_tick = (r_state == S_RUN) && w_tick;

  always_comb begin
    w_next = r_state;
    if (btn_mode) begin
      case (r_state)
        S_RUN:   w_next = S_HOUR;
        S_HOUR:  w_next = S_MIN;
        default: w_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || w_exit) r_cnt <= '0;
    else if (w_tick)   r_cnt <= '0;
    else               r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_hour     <= 6'd0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_run_tick;
      if (w_exit) begin
        r_sec <= 6'd0;
      end else if (w_run_tick) begin
        if (r_sec == 6'd59) begin
          r_sec <= 6'd0;
          if (r_min == 6'd59) begin
            r_min  <= 6'd0;
            r_hour <= (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else if (w_inc && r_state == S_HOUR) begin
        r_hour <= (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
      end else if (w_inc && r_state == S_MIN) begin
        r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      end
    end
  end

  assign second    = r_sec;
  assign minute    = r_min;
  assign sec_tick  = r_sec_tick;
  assign set_state = r_state;
  assign blink     = (r_state == S_RUN) ||
                     (r_cnt < CW'(TICK_DIV / 2));

`ifdef TIME_12H_EN
  always_comb begin
    hour = r_hour;
    if (r_hour == 6'd0)      hour = 6'd12;
    else if (r_hour > 6'd12) hour = r_hour - 6'd12;
  end
  assign pm = (r_hour >= 6'd12);
`else
  assign hour = r_hour;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter with TICK_DIV=4.
// Covers the 12-hour presentation when built with TIME_12H_EN.
module tb_clock_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] second;
  logic [5:0] minute;
  logic [5:0] hour;
  logic       sec_tick;
  logic [1:0] set_state;
  logic       blink;
`ifdef TIME_12H_EN
  logic       pm;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_time_counter #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .second    (second),
    .minute    (minute),
    .hour      (hour),
    .sec_tick  (sec_tick),
    .set_state (set_state),
    .blink     (blink)
`ifdef TIME_12H_EN
    ,
    .pm        (pm)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] eh(int h);
`ifdef TIME_12H_EN
    if (h == 0) return 6'd12;
    if (h > 12) return 6'(h - 12);
`endif
    return 6'(h);
  endfunction

  function automatic logic [17:0] tv(int h, int m, int s);
    return {eh(h), 6'(m), 6'(s)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
  endtask

  task automatic pulse_inc(int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      cyc();
    end
    btn_inc = 1'b0;
  endtask

  // Leaves the prescaler at 2 (first blink-low cycle) in a set state
  task automatic sync_cnt2(string name);
    int k;
    k = 0;
    while (blink !== 1'b1 && k < 8) begin
      cyc();
      k++;
    end
    while (blink !== 1'b0 && k < 16) begin
      cyc();
      k++;
    end
    n_checks++;
    if (blink !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: blink never fell, got %b want 0", name, blink);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({hour, minute, second} !== tv(0, 0, 0) || sec_tick !== 1'b0 ||
        set_state !== 2'b00 || blink !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got %0d:%0d:%0d t=%b s=%b b=%b want 0:0:0 0 00 1",
               hour, minute, second, sec_tick, set_state, blink);
    end
`ifdef TIME_12H_EN
    n_checks++;
    if (pm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pm: got %b want 0", pm);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (second !== 6'd0 || sec_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_tick%0d: got s=%0d t=%b want 0 0", i, second, sec_tick);
      end
    end
    cyc();
    n_checks++;
    if (second !== 6'd1 || sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick: got s=%0d t=%b want 1 1", second, sec_tick);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (sec_tick !== 1'b0 || second !== 6'd1) begin
        n_fail++;
        $display("FAIL tick_gap%0d: got s=%0d t=%b want 1 0", i, second, sec_tick);
      end
    end
    cyc();
    n_checks++;
    if (second !== 6'd2 || sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL second_tick: got s=%0d t=%b want 2 1", second, sec_tick);
    end
  endtask

  task automatic test_set_mode();
    repeat (12) cyc();
    n_checks++;
    if ({hour, minute, second} !== tv(0, 0, 5)) begin
      n_fail++;
      $display("FAIL run_5s: got %0d:%0d:%0d want 0:0:5", hour, minute, second);
    end
    pulse_mode();
    n_checks++;
    if (set_state !== 2'b01) begin
      n_fail++;
      $display("FAIL enter_hour: got %b want 01", set_state);
    end
    pulse_inc(25);
    n_checks++;
    if ({hour, minute, second} !== tv(1, 0, 5)) begin
      n_fail++;
      $display("FAIL hour_wrap: got %0d:%0d:%0d want 1:0:5", hour, minute, second);
    end
    pulse_mode();
    n_checks++;
    if (set_state !== 2'b10) begin
      n_fail++;
      $display("FAIL enter_min: got %b want 10", set_state);
    end
    pulse_inc(61);
    n_checks++;
    if ({hour, minute, second} !== tv(1, 1, 5) || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL min_wrap: got %0d:%0d:%0d t=%b want 1:1:5 0",
               hour, minute, second, sec_tick);
    end
    pulse_mode();
    n_checks++;
    if (set_state !== 2'b00 || {hour, minute, second} !== tv(1, 1, 0) ||
        blink !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_run: got s=%b %0d:%0d:%0d b=%b want 00 1:1:0 1",
               set_state, hour, minute, second, blink);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (second !== 6'd0 || sec_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL exit_gap%0d: got s=%0d t=%b want 0 0", i, second, sec_tick);
      end
    end
    cyc();
    n_checks++;
    if (second !== 6'd1 || sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_tick: got s=%0d t=%b want 1 1", second, sec_tick);
    end
  endtask

  task automatic test_simultaneous();
    pulse_mode();
    pulse_inc(4);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    n_checks++;
    if (set_state !== 2'b10 || hour !== eh(5)) begin
      n_fail++;
      $display("FAIL mode_wins: got s=%b h=%0d want 10 %0d", set_state, hour, eh(5));
    end
    pulse_mode();
    pulse_inc(1);
    n_checks++;
    if ({hour, minute, second} !== tv(5, 1, 0) || set_state !== 2'b00) begin
      n_fail++;
      $display("FAIL inc_in_run: got %0d:%0d:%0d s=%b want 5:1:0 00",
               hour, minute, second, set_state);
    end
  endtask

  task automatic test_reset_mid();
    pulse_mode();
    pulse_inc(2);
    pulse_mode();
    pulse_inc(29);
    sync_cnt2("mid_sync");
    n_checks++;
    if ({hour, minute} !== {eh(7), 6'd30} || set_state !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_setup: got %0d:%0d s=%b want 7:30 10", hour, minute, set_state);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({hour, minute, second} !== tv(0, 0, 0) || set_state !== 2'b00 ||
        blink !== 1'b1 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d:%0d:%0d s=%b b=%b t=%b want 0:0:0 00 1 0",
               hour, minute, second, set_state, blink, sec_tick);
    end
    repeat (3) cyc();
    n_checks++;
    if (second !== 6'd0 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_early: got s=%0d t=%b want 0 0", second, sec_tick);
    end
    cyc();
    n_checks++;
    if (second !== 6'd1 || sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_tick: got s=%0d t=%b want 1 1", second, sec_tick);
    end
  endtask

  task automatic test_rollover();
    pulse_mode();
    pulse_inc(23);
    pulse_mode();
    pulse_inc(59);
    pulse_mode();
    repeat (232) cyc();
    n_checks++;
    if ({hour, minute, second} !== tv(23, 59, 58)) begin
      n_fail++;
      $display("FAIL roll_58: got %0d:%0d:%0d want %0d:59:58",
               hour, minute, second, eh(23));
    end
    repeat (4) cyc();
    n_checks++;
    if ({hour, minute, second} !== tv(23, 59, 59)) begin
      n_fail++;
      $display("FAIL roll_59: got %0d:%0d:%0d want %0d:59:59",
               hour, minute, second, eh(23));
    end
    repeat (3) cyc();
    n_checks++;
    if ({hour, minute, second} !== tv(23, 59, 59)) begin
      n_fail++;
      $display("FAIL roll_hold: got %0d:%0d:%0d want %0d:59:59",
               hour, minute, second, eh(23));
    end
    cyc();
    n_checks++;
    if ({hour, minute, second} !== tv(0, 0, 0) || sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL roll_wrap: got %0d:%0d:%0d t=%b want %0d:0:0 1",
               hour, minute, second, sec_tick, eh(0));
    end
  endtask

  task automatic test_blink_12h();
    logic [3:0] exp_b;
    exp_b = 4'b1100;
    n_checks++;
    if (hour !== eh(0)) begin
      n_fail++;
      $display("FAIL h00: got %0d want %0d", hour, eh(0));
    end
`ifdef TIME_12H_EN
    n_checks++;
    if (pm !== 1'b0) begin
      n_fail++;
      $display("FAIL pm00: got %b want 0", pm);
    end
`endif
    pulse_mode();
    sync_cnt2("blink_sync");
    repeat (2) cyc();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (blink !== exp_b[3-i]) begin
          n_fail++;
          $display("FAIL blink%0d_%0d: got %b want %b", p, i, blink, exp_b[3-i]);
        end
        cyc();
      end
    end
    pulse_inc(12);
    n_checks++;
    if (hour !== eh(12)) begin
      n_fail++;
      $display("FAIL h12: got %0d want %0d", hour, eh(12));
    end
`ifdef TIME_12H_EN
    n_checks++;
    if (pm !== 1'b1) begin
      n_fail++;
      $display("FAIL pm12: got %b want 1", pm);
    end
`endif
    pulse_inc(1);
    n_checks++;
    if (hour !== eh(13)) begin
      n_fail++;
      $display("FAIL h13: got %0d want %0d", hour, eh(13));
    end
`ifdef TIME_12H_EN
    n_checks++;
    if (pm !== 1'b1) begin
      n_fail++;
      $display("FAIL pm13: got %b want 1", pm);
    end
`endif
  endtask

  initial begin
    #2;
    test_reset();
    test_set_mode();
    test_simultaneous();
    test_reset_mid();
    test_rollover();
    test_blink_12h();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
